// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared constants and helpers for the seven-segment scan controller.
//   SEG_PAT_0..9 : active-high {a,b,c,d,e,f,g} patterns, bit 6 = a
//   SEG_BLANK    : all segments off (active-high)
//   conv_state_e : converter FSM states
//   bcd_to_seg() : digit -> active-high pattern, blank for non-decimal codes
package seg_pkg;

   localparam logic [6:0] SEG_PAT_0 = 7'b1111110;
   localparam logic [6:0] SEG_PAT_1 = 7'b0110000;
   localparam logic [6:0] SEG_PAT_2 = 7'b1101101;
   localparam logic [6:0] SEG_PAT_3 = 7'b1111001;
   localparam logic [6:0] SEG_PAT_4 = 7'b0110011;
   localparam logic [6:0] SEG_PAT_5 = 7'b1011011;
   localparam logic [6:0] SEG_PAT_6 = 7'b1011111;
   localparam logic [6:0] SEG_PAT_7 = 7'b1110000;
   localparam logic [6:0] SEG_PAT_8 = 7'b1111111;
   localparam logic [6:0] SEG_PAT_9 = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // number of shift-and-add-3 steps for a 6-bit input
   localparam int CONV_STEPS = 6;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_e;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = SEG_PAT_0;
         4'd1:    p = SEG_PAT_1;
         4'd2:    p = SEG_PAT_2;
         4'd3:    p = SEG_PAT_3;
         4'd4:    p = SEG_PAT_4;
         4'd5:    p = SEG_PAT_5;
         4'd6:    p = SEG_PAT_6;
         4'd7:    p = SEG_PAT_7;
         4'd8:    p = SEG_PAT_8;
         4'd9:    p = SEG_PAT_9;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: value-load handshake plus display pin bundle.
//   load  : request to display value (master -> slave)
//   value : 6-bit binary value 0..63 (master -> slave)
//   ready : slave can accept a load
//   seg_n : segments {a..g}, bit 6 = a, active-low
//   an_n  : digit enables, bit 0 = ones, bit 1 = tens, active-low
interface seg_scan_ctrl_if;
   logic       load;
   logic [5:0] value;
   logic       ready;
   logic [6:0] seg_n;
   logic [1:0] an_n;

   modport master (output load, value, input  ready, seg_n, an_n);
   modport slave  (input  load, value, output ready, seg_n, an_n);
endinterface

// File: rtl/seg_scan_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: sequential 6-bit double-dabble converter.
//   clk, rst : clock, synchronous active-high reset
//   start    : capture bin and begin converting (honoured in IDLE only)
//   bin      : 6-bit binary input
//   done     : high in the cycle whose clock edge completes step 6
//   tens/ones: result digits, valid while done is high
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] bin,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   conv_state_e state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [5:0]  sh_q, sh_d;
   logic [7:0]  bcd_q, bcd_d;

   logic [7:0]  adj;
   logic [13:0] shifted;

   always_comb begin
      // add 3 to any nibble >= 5, then shift the whole {bcd, bin} chain left
      adj = bcd_q;
      if (bcd_q[3:0] >= 4'd5) adj[3:0] = bcd_q[3:0] + 4'd3;
      if (bcd_q[7:4] >= 4'd5) adj[7:4] = bcd_q[7:4] + 4'd3;
      shifted = {adj[6:0], sh_q, 1'b0};

      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      done    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = bin;
               bcd_d   = 8'h00;
               cnt_d   = 3'd0;
               state_d = CONV;
            end
         end
         CONV: begin
            bcd_d = shifted[13:6];
            sh_d  = shifted[5:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(CONV_STEPS - 1)) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // result is taken from the step being committed so the caller can
   // latch it on the same edge
   assign tens = bcd_d[7:4];
   assign ones = bcd_d[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         sh_q    <= 6'd0;
         bcd_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: accepts a 6-bit value over a load/ready handshake, converts
// it to two BCD digits and time-multiplexes them onto a shared active-low
// segment bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seg_scan_ctrl_if.slave (load, value, ready, seg_n, an_n)
// Parameters: SCAN_DIV cycles per digit slot (>= 4), GUARD blanking cycles at
// the start of each slot (< SCAN_DIV).
// Build option: SEG_SCAN_BLANK_LZ_EN blanks the tens slot when tens digit is 0.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int GUARD    = 2
)(
   input  logic        clk,
   input  logic        rst,
   seg_scan_ctrl_if.slave bus
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic             ready_q, ready_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       ones_q, ones_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             sel_q, sel_d;
   logic [6:0]       seg_n_q, seg_n_d;
   logic [1:0]       an_n_q, an_n_d;

   logic       accept;
   logic       conv_done;
   logic [3:0] conv_tens, conv_ones;
   logic [3:0] digit;
   logic       blank;

   assign accept = bus.load & ready_q;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .bin   (bus.value),
      .done  (conv_done),
      .tens  (conv_tens),
      .ones  (conv_ones)
   );

   // handshake and digit commit
   always_comb begin
      ready_d = ready_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      if (accept) ready_d = 1'b0;
      if (conv_done) begin
         ready_d = 1'b1;
         tens_d  = conv_tens;
         ones_d  = conv_ones;
      end
   end

   // free-running scanner; outputs are computed from next-state values so the
   // registered pins line up with div_q/sel_q
   always_comb begin
      div_d = div_q + DIV_W'(1);
      sel_d = sel_q;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
         div_d = '0;
         sel_d = ~sel_q;
      end

      digit = sel_d ? tens_d : ones_d;
      blank = (32'(div_d) < 32'(GUARD));
`ifdef SEG_SCAN_BLANK_LZ_EN
      if (sel_d && (tens_d == 4'd0)) blank = 1'b1;
`endif
      if (blank) begin
         seg_n_d = 7'h7F;
         an_n_d  = 2'b11;
      end else begin
         seg_n_d = ~bcd_to_seg(digit);
         an_n_d  = sel_d ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b1;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         div_q   <= '0;
         sel_q   <= 1'b0;
         seg_n_q <= 7'h7F;
         an_n_q  <= 2'b11;
      end else begin
         ready_q <= ready_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         div_q   <= div_d;
         sel_q   <= sel_d;
         seg_n_q <= seg_n_d;
         an_n_q  <= an_n_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.seg_n = seg_n_q;
   assign bus.an_n  = an_n_q;

endmodule
